// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : Operand store and IDLE->EXEC->WB sequencer feeding a registered
//            3-bit-opcode ALU. Optional ALU_SEQ_STICKY_FLAGS_EN adds flag_clr
//            and OR-accumulating carry/overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs2,
    input  logic [AW-1:0]    in_rs3,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] alu_r2,
    output logic [WIDTH-1:0] alu_r3,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r1,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    output logic             done,
    output logic             flag_zero,
    output logic             flag_carry,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    input  logic             flag_clr,
`endif
    output logic             flag_ovf
);

    localparam int c_DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_rf_q [c_DEPTH];
    logic [WIDTH-1:0] w_rf_d [c_DEPTH];
    logic [WIDTH-1:0] r_r2_q, w_r2_d;
    logic [WIDTH-1:0] r_r3_q, w_r3_d;
    logic [2:0]       r_op_q, w_op_d;
    logic [AW-1:0]    r_rd_q, w_rd_d;
    logic             r_done_q, w_done_d;
    logic             r_zero_q, w_zero_d;
    logic             r_carry_q, w_carry_d;
    logic             r_ovf_q, w_ovf_d;

    always_comb begin
        w_state_d = r_state_q;
        for (int i = 0; i < c_DEPTH; i++) begin
            w_rf_d[i] = r_rf_q[i];
        end
        w_r2_d    = r_r2_q;
        w_r3_d    = r_r3_q;
        w_op_d    = r_op_q;
        w_rd_d    = r_rd_q;
        w_done_d  = 1'b0;
        w_zero_d  = r_zero_q;
        w_carry_d = r_carry_q;
        w_ovf_d   = r_ovf_q;

        case (r_state_q)
            S_IDLE: begin
                if (ld_en) begin
                    w_rf_d[ld_addr] = ld_data;
                end
                // Operands come from the pre-load array: no load-to-read bypass.
                if (in_valid) begin
                    w_r2_d    = r_rf_q[in_rs2];
                    w_r3_d    = r_rf_q[in_rs3];
                    w_op_d    = in_op;
                    w_rd_d    = in_rd;
                    w_state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_d = S_WB;
            end
            S_WB: begin
                w_rf_d[r_rd_q] = alu_r1;
                w_zero_d       = (alu_r1 == '0);
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                w_carry_d      = r_carry_q | alu_carry;
                w_ovf_d        = r_ovf_q | alu_ovf;
`else
                w_carry_d      = alu_carry;
                w_ovf_d        = alu_ovf;
`endif
                w_done_d       = 1'b1;
                w_state_d      = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

`ifdef ALU_SEQ_STICKY_FLAGS_EN
        if (flag_clr) begin
            w_carry_d = 1'b0;
            w_ovf_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_rf_q[i] <= '0;
            end
            r_r2_q    <= '0;
            r_r3_q    <= '0;
            r_op_q    <= '0;
            r_rd_q    <= '0;
            r_done_q  <= 1'b0;
            r_zero_q  <= 1'b0;
            r_carry_q <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_rf_q[i] <= w_rf_d[i];
            end
            r_r2_q    <= w_r2_d;
            r_r3_q    <= w_r3_d;
            r_op_q    <= w_op_d;
            r_rd_q    <= w_rd_d;
            r_done_q  <= w_done_d;
            r_zero_q  <= w_zero_d;
            r_carry_q <= w_carry_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign in_ready   = (r_state_q == S_IDLE);
    assign dbg_data   = r_rf_q[dbg_addr];
    assign alu_r2     = r_r2_q;
    assign alu_r3     = r_r3_q;
    assign alu_op     = r_op_q;
    assign done       = r_done_q;
    assign flag_zero  = r_zero_q;
    assign flag_carry = r_carry_q;
    assign flag_ovf   = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Brief    : Self-checking bench for alu_seq_ctrl with a registered ALU model
//            and an expected-result queue. Honours ALU_SEQ_STICKY_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    localparam bit c_STICKY = 1'b1;
    logic flag_clr;
`else
    localparam bit c_STICKY = 1'b0;
`endif

    localparam logic [2:0] c_ADD = 3'b010;
    localparam logic [2:0] c_SUB = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  in_op, in_rd, in_rs2, in_rs3;
    logic        ld_en;
    logic [2:0]  ld_addr, dbg_addr;
    logic [31:0] ld_data, dbg_data;
    logic [31:0] alu_r2, alu_r3, alu_r1;
    logic [2:0]  alu_op;
    logic        alu_carry, alu_ovf;
    logic        done, flag_zero, flag_carry, flag_ovf;

    typedef struct {
        logic [2:0]  rd;
        logic [31:0] val;
        logic        c;
        logic        v;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rf [8];
    logic        model_c, model_v;
    logic [33:0] alu_t;
    int          checks = 0;
    int          failures = 0;

    alu_seq_ctrl #(.WIDTH(32), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_r2(alu_r2), .alu_r3(alu_r3), .alu_op(alu_op),
        .alu_r1(alu_r1), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .done(done), .flag_zero(flag_zero), .flag_carry(flag_carry),
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        .flag_clr(flag_clr),
`endif
        .flag_ovf(flag_ovf)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {ovf, carry, result}
    function automatic logic [33:0] alu_ref(input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0; v = 1'b0; r = '0;
        case (op)
            3'b000: r = a;
            3'b001: r = ~a;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b011: r = ~(a | b);
            3'b100: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b101: r = ~(a & b);
            3'b110: r = a & b;
            default: r = {31'd0, ($signed(a) < $signed(b))};
        endcase
        return {v, c, r};
    endfunction

    // Registered ALU: samples its inputs each edge, result valid one cycle later
    always @(posedge clk) begin
        alu_t = alu_ref(alu_op, alu_r2, alu_r3);
        alu_r1    <= alu_t[31:0];
        alu_carry <= alu_t[32];
        alu_ovf   <= alu_t[33];
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        model_c = 1'b0;
        model_v = 1'b0;
        sb.delete();
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        model_rf[a] = d;
    endtask

    task automatic push(input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs2, input logic [2:0] rs3);
        logic [33:0] t;
        t = alu_ref(op, model_rf[rs2], model_rf[rs3]);
        sb.push_back('{rd: rd, val: t[31:0], c: t[32], v: t[33]});
    endtask

    // Returns at #1 after the accept edge, i.e. in the EXEC cycle.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs2, input logic [2:0] rs3);
        int k;
        in_op = op; in_rd = rd; in_rs2 = rs2; in_rs3 = rs3; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
        @(posedge clk);
        push(op, rd, rs2, rs3);
        #1;
        in_valid = 1'b0;
    endtask

    // n = edges until done is seen; to = no done within the budget
    task automatic wait_done(output int n, output bit to);
        n = 0; to = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; n++;
            if (done) begin to = 1'b0; break; end
        end
    endtask

    // Pops the oldest expectation, folds flags as the build does, points dbg at rd.
    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{rd: 3'd0, val: 32'hDEAD_BEEF, c: 1'b0, v: 1'b0};
        model_c = c_STICKY ? (model_c | e.c) : e.c;
        model_v = c_STICKY ? (model_v | e.v) : e.v;
        e.c = model_c;
        e.v = model_v;
        model_rf[e.rd] = e.val;
        dbg_addr = e.rd;
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, done, flag_zero, flag_carry, flag_ovf} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 10000", {in_ready, done, flag_zero, flag_carry, flag_ovf});
        end
        checks++;
        if ({alu_op, alu_r2, alu_r3} !== 67'd0) begin
            failures++;
            $display("FAIL reset_alu_ports: got op=%0h r2=%0h r3=%0h want 0", alu_op, alu_r2, alu_r3);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            checks++;
            if (dbg_data !== 32'd0) begin
                failures++;
                $display("FAIL reset_rf r%0d: got %h want 0", i, dbg_data);
            end
        end
    endtask

    task automatic test_add_basic();
        exp_t e; int n; bit to;
        load(3'd1, 32'd5);
        load(3'd2, 32'd7);
        issue(c_ADD, 3'd3, 3'd1, 3'd2);
        checks++;
        if ({alu_op, alu_r2, alu_r3} !== {3'b010, 32'd5, 32'd7}) begin
            failures++;
            $display("FAIL add_operands: got op=%b r2=%0d r3=%0d want 010/5/7", alu_op, alu_r2, alu_r3);
        end
        wait_done(n, to);
        checks++;
        if (to || n != 2) begin
            failures++;
            $display("FAIL add_latency: got %0d edges after accept (timeout=%0d) want 2", n, to);
        end
        pop_exp(e);
        checks++;
        if (dbg_data !== 32'd12) begin
            failures++;
            $display("FAIL add_result: got %0d want 12", dbg_data);
        end
        checks++;
        if ({flag_zero, flag_carry, flag_ovf} !== 3'b000) begin
            failures++;
            $display("FAIL add_flags: got %b want 000", {flag_zero, flag_carry, flag_ovf});
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: got %b want 0", done);
        end
    endtask

    task automatic test_sub_zero();
        exp_t e; int n; bit to;
        load(3'd4, 32'h1234);
        issue(c_SUB, 3'd5, 3'd4, 3'd4);
        wait_done(n, to);
        pop_exp(e);
        checks++;
        if (to || dbg_data !== 32'd0 || flag_zero !== 1'b1) begin
            failures++;
            $display("FAIL sub_zero: got r5=%h zero=%b timeout=%0d want 0/1/0", dbg_data, flag_zero, to);
        end
        // Asymmetric operands catch swapped R2/R3.
        issue(c_SUB, 3'd2, 3'd4, 3'd1);
        wait_done(n, to);
        pop_exp(e);
        checks++;
        if (to || dbg_data !== e.val || dbg_data !== 32'h122F) begin
            failures++;
            $display("FAIL sub_order: got %h want 0000122f", dbg_data);
        end
    endtask

    task automatic test_ovf_carry();
        exp_t e; int n; bit to;
        load(3'd1, 32'h7FFF_FFFF);
        load(3'd2, 32'd1);
        issue(c_ADD, 3'd6, 3'd1, 3'd2);
        wait_done(n, to);
        pop_exp(e);
        checks++;
        if (to || dbg_data !== 32'h8000_0000 || {flag_zero, flag_carry, flag_ovf} !== {1'b0, e.c, 1'b1}) begin
            failures++;
            $display("FAIL add_ovf: got r6=%h zc v=%b want 80000000 %b", dbg_data,
                     {flag_zero, flag_carry, flag_ovf}, {1'b0, e.c, 1'b1});
        end
        load(3'd1, 32'hFFFF_FFFF);
        issue(c_ADD, 3'd6, 3'd1, 3'd2);
        wait_done(n, to);
        pop_exp(e);
        checks++;
        if (to || dbg_data !== 32'd0 || {flag_zero, flag_carry, flag_ovf} !== {1'b1, 1'b1, e.v}) begin
            failures++;
            $display("FAIL add_carry: got r6=%h zcv=%b want 0 %b", dbg_data,
                     {flag_zero, flag_carry, flag_ovf}, {1'b1, 1'b1, e.v});
        end
    endtask

    task automatic test_load_accept();
        exp_t e; int n; bit to;
        // r1 = ffffffff, r2 = 1: load r1=5 alongside accept of r1 <- r1 + r2
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'd5;
        in_op = c_ADD; in_rd = 3'd1; in_rs2 = 3'd1; in_rs3 = 3'd2; in_valid = 1'b1;
        @(posedge clk);
        push(c_ADD, 3'd1, 3'd1, 3'd2);
        model_rf[1] = 32'd5;
        #1;
        ld_en = 1'b0; in_valid = 1'b0;
        dbg_addr = 3'd1; #1;
        checks++;
        if (dbg_data !== 32'd5 || alu_r2 !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL load_with_accept: got r1=%h r2op=%h want 5/ffffffff", dbg_data, alu_r2);
        end
        wait_done(n, to);
        pop_exp(e);
        checks++;
        if (to || dbg_data !== 32'd0) begin
            failures++;
            $display("FAIL wb_overwrites_load: got r1=%h want 0", dbg_data);
        end
        issue(c_ADD, 3'd0, 3'd2, 3'd2);
        wait_done(n, to);
        pop_exp(e);
        checks++;
        if (to || dbg_data !== 32'd2) begin
            failures++;
            $display("FAIL write_r0: got %h want 2", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; int n; bit to;
        load(3'd7, 32'd3);
        load(3'd1, 32'd40);
        in_op = c_SUB; in_rd = 3'd2; in_rs2 = 3'd1; in_rs3 = 3'd7; in_valid = 1'b1;
        @(posedge clk);
        push(c_SUB, 3'd2, 3'd1, 3'd7);
        #1;
        // Second instruction depends on the first's writeback.
        in_op = c_ADD; in_rd = 3'd6; in_rs2 = 3'd2; in_rs3 = 3'd1;
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 32'd9;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_exec: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_wb: got %b want 0", in_ready);
        end
        wait_done(n, to);
        checks++;
        if (to || n != 1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_done: got edges=%0d ready=%b timeout=%0d want 1/1/0", n, in_ready, to);
        end
        pop_exp(e);
        checks++;
        if (dbg_data !== 32'd37) begin
            failures++;
            $display("FAIL b2b_first_result: got %0d want 37", dbg_data);
        end
        @(posedge clk);
        push(c_ADD, 3'd6, 3'd2, 3'd1);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || alu_r2 !== 32'd37 || alu_op !== c_ADD) begin
            failures++;
            $display("FAIL b2b_second_accept: got ready=%b r2=%0d op=%b want 0/37/010", in_ready, alu_r2, alu_op);
        end
        wait_done(n, to);
        pop_exp(e);
        checks++;
        if (to || n != 2 || dbg_data !== 32'd77) begin
            failures++;
            $display("FAIL b2b_second_result: got %0d edges=%0d want 77/2", dbg_data, n);
        end
        dbg_addr = 3'd7; #1;
        checks++;
        if (dbg_data !== model_rf[7]) begin
            failures++;
            $display("FAIL ld_ignored_exec: got r7=%0d want %0d", dbg_data, model_rf[7]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        load(3'd1, 32'd10);
        load(3'd2, 32'd20);
        issue(c_ADD, 3'd3, 3'd1, 3'd2);
        rst = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got ready=%b done=%b want 1/0", in_ready, done);
        end
        rst = 1'b0;
        model_clear();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abandon_no_done: got done pulse=%b want 0", seen);
        end
        dbg_addr = 3'd3; #1;
        checks++;
        if (dbg_data !== 32'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abandon_no_wb: got r3=%h ready=%b want 0/1", dbg_data, in_ready);
        end
    endtask

    task automatic test_flags();
        exp_t e; int n; bit to;
        load(3'd1, 32'h7FFF_FFFF);
        load(3'd2, 32'd1);
        issue(c_ADD, 3'd6, 3'd1, 3'd2);
        wait_done(n, to);
        pop_exp(e);
        load(3'd1, 32'd1);
        issue(c_ADD, 3'd4, 3'd1, 3'd2);
        wait_done(n, to);
        pop_exp(e);
        checks++;
        if (to || dbg_data !== 32'd2 || flag_ovf !== c_STICKY) begin
            failures++;
            $display("FAIL ovf_after_1p1: got r4=%0d ovf=%b want 2/%b", dbg_data, flag_ovf, c_STICKY);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({flag_zero, flag_carry, flag_ovf} !== {1'b0, e.c, e.v}) begin
            failures++;
            $display("FAIL flags_hold_idle: got %b want %b", {flag_zero, flag_carry, flag_ovf}, {1'b0, e.c, e.v});
        end
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        model_c = 1'b0; model_v = 1'b0;
        checks++;
        if (flag_ovf !== 1'b0 || flag_carry !== 1'b0) begin
            failures++;
            $display("FAIL flag_clr: got c=%b v=%b want 0/0", flag_carry, flag_ovf);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs2 = '0; in_rs3 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        flag_clr = 1'b0;
`endif
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_add_basic();
        test_sub_zero();
        test_ovf_carry();
        test_load_accept();
        test_back_to_back();
        test_reset_mid();
        test_flags();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
